// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns halt, branch, multi-cycle ALU, RAW hazard
// and external-wait events into stall/flush controls for the fetch/decode/
// execute registers, and counts stalled cycles for performance monitoring.
//
// state | meaning
// RUN   | normal flow; highest-priority active event decides the controls
// MULTI | multi-cycle ALU op in execute; front end held, all events ignored
// HALT  | halt retired; pipeline frozen until reset
module pipe_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   rst_l,
  input  logic                   halt_E,
  input  logic                   branch_taken_E,
  input  logic                   mc_start_E,
  input  logic [2:0]             mc_cycles,
  input  logic                   raw_hazard_D,
  input  logic                   ext_hold,
  output logic                   stall,
  output logic                   flush,
  output logic                   flush_DE,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  state_t     w_state_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_stall;
  logic       w_flush;
  logic       w_flush_DE;
  logic       w_halted;

  // Decode controls and next state from current state, remaining count and events.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_flush_DE  = 1'b0;
    w_halted    = 1'b0;
    if (!rst_l) begin
      // Hold the front end empty while reset is asserted.
      w_flush    = 1'b1;
      w_flush_DE = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_E) begin
            w_stall     = 1'b1;
            w_flush_DE  = 1'b1;
            w_state_nxt = HALT;
          end else if (branch_taken_E) begin
            w_flush    = 1'b1;
            w_flush_DE = 1'b1;
          end else if (mc_start_E) begin
            // The start cycle itself is the first stall; MULTI covers the rest.
            if (mc_cycles >= 3'd2) w_stall = 1'b1;
            if (mc_cycles >= 3'd3) begin
              w_cnt_nxt   = mc_cycles - 3'd2;
              w_state_nxt = MULTI;
            end
          end else if (raw_hazard_D || ext_hold) begin
            w_stall    = 1'b1;
            w_flush_DE = 1'b1;
          end
        end
        MULTI: begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = RUN;
        end
        HALT: begin
          w_stall    = 1'b1;
          w_flush_DE = 1'b1;
          w_halted   = 1'b1;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // State, op countdown and saturating stall counter; reset is synchronous.
  always_ff @(posedge clock) begin
    if (!rst_l) begin
      r_state        <= RUN;
      r_cnt          <= 3'd0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_cycles != {STALL_CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall        = w_stall;
  assign flush        = w_flush;
  assign flush_DE     = w_flush_DE;
  assign halted       = w_halted;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level model that tracks "stall cycles still owed" and a
// halted flag rather than the controller's states.
module tb_pipe_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_l, halt_E, branch_taken_E, mc_start_E, raw_hazard_D, ext_hold;
  logic [2:0]  mc_cycles;
  logic        stall, flush, flush_DE, halted;
  logic [15:0] stall_cycles;
  logic        stall4, flush4, flush_DE4, halted4;
  logic [3:0]  stall_cycles4;

  pipe_ctrl #(.STALL_CNT_W(16)) dut (
    .clock(clock), .rst_l(rst_l), .halt_E(halt_E), .branch_taken_E(branch_taken_E),
    .mc_start_E(mc_start_E), .mc_cycles(mc_cycles), .raw_hazard_D(raw_hazard_D),
    .ext_hold(ext_hold), .stall(stall), .flush(flush), .flush_DE(flush_DE),
    .halted(halted), .stall_cycles(stall_cycles));

  pipe_ctrl #(.STALL_CNT_W(4)) dut4 (
    .clock(clock), .rst_l(rst_l), .halt_E(halt_E), .branch_taken_E(branch_taken_E),
    .mc_start_E(mc_start_E), .mc_cycles(mc_cycles), .raw_hazard_D(raw_hazard_D),
    .ext_hold(ext_hold), .stall(stall4), .flush(flush4), .flush_DE(flush_DE4),
    .halted(halted4), .stall_cycles(stall_cycles4));

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit e_stall, e_flush, e_flush_DE, e_halted;
  int m_busy = 0;     // stall cycles still owed to a multi-cycle op
  bit m_halt = 0;
  int m_cnt = 0;
  int m_cnt4 = 0;
  int n_busy;
  bit n_halt;

  // Drive one cycle of inputs after the falling edge and predict the controls.
  task automatic apply(input bit r, input bit h, input bit b, input bit m,
                       input int mcc, input bit rw, input bit ex);
    @(negedge clock);
    rst_l = r; halt_E = h; branch_taken_E = b; mc_start_E = m;
    mc_cycles = 3'(mcc); raw_hazard_D = rw; ext_hold = ex;
    #1;
    e_stall = 0; e_flush = 0; e_flush_DE = 0; e_halted = 0;
    n_busy = m_busy; n_halt = m_halt;
    if (!r) begin
      e_flush = 1; e_flush_DE = 1; n_busy = 0; n_halt = 0;
    end else if (m_halt) begin
      e_stall = 1; e_flush_DE = 1; e_halted = 1;
    end else if (m_busy > 0) begin
      e_stall = 1; n_busy = m_busy - 1;
    end else if (h) begin
      e_stall = 1; e_flush_DE = 1; n_halt = 1;
    end else if (b) begin
      e_flush = 1; e_flush_DE = 1;
    end else if (m) begin
      if (mcc >= 2) e_stall = 1;
      if (mcc >= 3) n_busy = mcc - 2;
    end else if (rw || ex) begin
      e_stall = 1; e_flush_DE = 1;
    end
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    @(posedge clock);
    if (!rst_l) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (e_stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    m_busy = n_busy; m_halt = n_halt;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom));
      checks++;
      if ({stall, flush, flush_DE, halted} !== 4'b0110) begin
        errors++; $display("FAIL reset_outputs got %b want 0110", {stall, flush, flush_DE, halted});
      end
      if (i > 0) begin
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles4 !== 4'd0) begin
          errors++; $display("FAIL reset_counter got %0d/%0d want 0", stall_cycles, stall_cycles4);
        end
      end
      tick();
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({stall, flush, flush_DE, halted} !== 4'b0000) begin
      errors++; $display("FAIL first_run_idle got %b want 0000", {stall, flush, flush_DE, halted});
    end
    tick();
  endtask

  task automatic test_multi_cycle();
    int nst = 0;
    int base = m_cnt;
    for (int i = 0; i < 7; i++) begin
      apply(1, 0, 0, (i == 0), 5, 0, 0);
      checks++;
      if ({stall, flush, flush_DE, halted} !== {e_stall, e_flush, e_flush_DE, e_halted}) begin
        errors++; $display("FAIL mc5_cycle%0d got %b want %b", i,
          {stall, flush, flush_DE, halted}, {e_stall, e_flush, e_flush_DE, e_halted});
      end
      if (stall) nst++;
      tick();
    end
    checks++;
    if (nst != 4) begin errors++; $display("FAIL mc5_stall_len got %0d want 4", nst); end
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (int'(stall_cycles) != base + 4) begin
      errors++; $display("FAIL mc5_stall_cycles got %0d want %0d", stall_cycles, base + 4);
    end
    tick();
    // Short ops: 0/1 cycles do nothing, 2 stalls a single cycle, 3 stalls two.
    for (int c = 0; c < 4; c++) begin
      nst = 0;
      for (int i = 0; i < 4; i++) begin
        apply(1, 0, 0, (i == 0), c, 0, 0);
        if (stall) nst++;
        tick();
      end
      checks++;
      if (nst != ((c <= 1) ? 0 : c - 1)) begin
        errors++; $display("FAIL mc%0d_stall_len got %0d want %0d", c, nst, (c <= 1) ? 0 : c - 1);
      end
    end
  endtask

  task automatic test_priority();
    int base = m_cnt;
    apply(1, 0, 1, 0, 0, 1, 0);
    checks++;
    if ({stall, flush, flush_DE} !== 3'b011) begin
      errors++; $display("FAIL branch_over_raw got %b want 011", {stall, flush, flush_DE});
    end
    tick();
    apply(1, 0, 1, 1, 6, 1, 1);
    checks++;
    if ({stall, flush, flush_DE} !== 3'b011) begin
      errors++; $display("FAIL branch_over_all got %b want 011", {stall, flush, flush_DE});
    end
    tick();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (int'(stall_cycles) != base) begin
      errors++; $display("FAIL branch_stall_cycles got %0d want %0d", stall_cycles, base);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0, 0, 1, 1);
      checks++;
      if ({stall, flush, flush_DE} !== 3'b101) begin
        errors++; $display("FAIL raw_bubble%0d got %b want 101", i, {stall, flush, flush_DE});
      end
      tick();
    end
  endtask

  task automatic test_multi_ignores();
    int nst = 0;
    for (int i = 0; i < 9; i++) begin
      apply(1, (i == 2), (i == 2), (i == 0) || (i == 3), 7, (i == 4), (i == 5));
      checks++;
      if ({stall, flush, flush_DE, halted} !== {e_stall, e_flush, e_flush_DE, e_halted}) begin
        errors++; $display("FAIL mc7_cycle%0d got %b want %b", i,
          {stall, flush, flush_DE, halted}, {e_stall, e_flush, e_flush_DE, e_halted});
      end
      if (i < 6 && stall) nst++;
      tick();
    end
    checks++;
    if (nst != 6 || halted !== 1'b0) begin
      errors++; $display("FAIL mc7_ignore got stalls=%0d halted=%b want 6/0", nst, halted);
    end
  endtask

  task automatic test_halt();
    apply(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({stall, flush, flush_DE, halted} !== 4'b1010) begin
      errors++; $display("FAIL halt_entry got %b want 1010", {stall, flush, flush_DE, halted});
    end
    tick();
    for (int i = 0; i < 22; i++) begin
      apply(1, 0, 1'($urandom), 1'($urandom), 5, 1'($urandom), 0);
      checks++;
      if ({stall, flush, flush_DE, halted} !== 4'b1011) begin
        errors++; $display("FAIL halt_hold%0d got %b want 1011", i, {stall, flush, flush_DE, halted});
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({stall, flush, flush_DE, halted} !== 4'b0110) begin
      errors++; $display("FAIL halt_reset got %b want 0110", {stall, flush, flush_DE, halted});
    end
    tick();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (halted !== 1'b0 || stall !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL halt_exit got halted=%b stall=%b cnt=%0d want 0/0/0",
        halted, stall, stall_cycles);
    end
    tick();
  endtask

  task automatic test_saturate();
    apply(0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      apply(1, 0, 0, 0, 0, 0, 1);
      checks++;
      if (int'(stall_cycles4) != m_cnt4) begin
        errors++; $display("FAIL sat_step%0d got %0d want %0d", i, stall_cycles4, m_cnt4);
      end
      tick();
    end
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cycles4 !== 4'd15 || stall_cycles !== 16'd20) begin
      errors++; $display("FAIL sat_final got %0d/%0d want 15/20", stall_cycles4, stall_cycles);
    end
    tick();
  endtask

  task automatic test_reset_in_multi();
    apply(1, 0, 0, 1, 6, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({stall, flush, flush_DE} !== 3'b011) begin
      errors++; $display("FAIL multi_reset got %b want 011", {stall, flush, flush_DE});
    end
    tick();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({stall, flush, flush_DE, halted} !== 4'b0000 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL multi_reset_after got %b cnt=%0d want 0000 cnt=0",
        {stall, flush, flush_DE, halted}, stall_cycles);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 99) >= 2),
            ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 20),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 15));
      checks++;
      if ({stall, flush, flush_DE, halted} !== {e_stall, e_flush, e_flush_DE, e_halted} ||
          int'(stall_cycles) != m_cnt || int'(stall_cycles4) != m_cnt4) begin
        errors++; $display("FAIL random%0d got %b %0d/%0d want %b %0d/%0d", i,
          {stall, flush, flush_DE, halted}, stall_cycles, stall_cycles4,
          {e_stall, e_flush, e_flush_DE, e_halted}, m_cnt, m_cnt4);
      end
      tick();
    end
  endtask

  initial begin
    rst_l = 1'b0; halt_E = 1'b0; branch_taken_E = 1'b0; mc_start_E = 1'b0;
    mc_cycles = 3'd0; raw_hazard_D = 1'b0; ext_hold = 1'b0;
    test_reset();
    test_multi_cycle();
    test_priority();
    test_multi_ignores();
    test_halt();
    test_saturate();
    test_reset_in_multi();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, 16, width of stall-cycle performance counter.
REQ-002 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_l  in  1  synchronous, active-low reset.
REQ-004 Port: halt_E  in  1  halt-decoded instruction in execute stage.
REQ-005 Port: branch_taken_E  in  1  branch resolved taken in execute.
REQ-006 Port: mc_start_E  in  1  multi-cycle ALU op (MP, DV) entered execute this cycle.
REQ-007 Port: mc_cycles  in  3  total execute cycles of that op; sampled only with mc_start_E.
REQ-008 Port: raw_hazard_D  in  1  decode needs a result that cannot be forwarded yet.
REQ-009 Port: ext_hold  in  1  external wait (memory/IO not ready).
REQ-010 Port: stall  out  1  hold PC, fetch/decode registers (drives decode stall).
REQ-011 Port: flush  out  1  clear fetch/decode registers (drives decode flush).
REQ-012 Port: flush_DE  out  1  insert bubble into decode->execute register (drives decode flush_DE).
REQ-013 Port: halted  out  1  pipeline permanently halted.
REQ-014 Port: stall_cycles  out  STALL_CNT_W  count of cycles with stall=1.

Function
REQ-015 FSM states: RUN, MULTI, HALT; outputs are combinational from state, counter and inputs.
REQ-016 RUN priority, highest first: halt_E, branch_taken_E, mc_start_E, raw_hazard_D, ext_hold; only the highest active event acts; lower ones are ignored that cycle.
REQ-017 RUN + halt_E: stall=1, flush_DE=1 same cycle; next state HALT.
REQ-018 RUN + branch_taken_E: flush=1, flush_DE=1, stall=0 for exactly that cycle; state stays RUN.
REQ-019 RUN + mc_start_E with mc_cycles<=1: no effect.
REQ-020 RUN + mc_start_E with mc_cycles==2: stall=1 that cycle only; stays RUN.
REQ-021 RUN + mc_start_E with mc_cycles>=3: stall=1 that cycle; load cnt=mc_cycles-2; next state MULTI.
REQ-022 MULTI: stall=1, flush=0, flush_DE=0 every cycle; cnt decrements each cycle; cnt==1 -> next RUN; total stall length of an op = mc_cycles-1 cycles.
REQ-023 MULTI ignores halt_E, branch_taken_E, raw_hazard_D, ext_hold, mc_start_E.
REQ-024 RUN + raw_hazard_D: stall=1 and flush_DE=1 (bubble) that cycle; repeats each cycle while asserted.
REQ-025 RUN + ext_hold: stall=1, flush_DE=1 that cycle; repeats while asserted.
REQ-026 RUN with no event: stall=flush=flush_DE=0.
REQ-027 HALT: stall=1, flush_DE=1, flush=0, halted=1 every cycle; exit only via reset.
REQ-028 stall_cycles increments by 1 on each rising edge where stall=1 and rst_l=1; saturates at all-ones, no wrap.
REQ-029 cnt is 3 bits; never underflows (MULTI entered only with cnt>=1).

Reset
REQ-030 rst_l=0 at an edge: state=RUN, cnt=0, stall_cycles=0, halted=0, from any state incl. mid-MULTI and HALT.
REQ-031 While rst_l=0: stall=0, flush=1, flush_DE=1, halted=0, regardless of other inputs.
REQ-032 First cycle after rst_l rises: RUN behaviour per REQ-016..026.

Verification
REQ-033 mc_start_E=1, mc_cycles=5 in RUN, other inputs 0 -> stall=1 for exactly 4 consecutive cycles, then 0; stall_cycles=4.
REQ-034 branch_taken_E=1 and raw_hazard_D=1 same cycle in RUN -> flush=1, flush_DE=1, stall=0 for one cycle; stall_cycles unchanged.
REQ-035 mc_start_E, mc_cycles=7; branch_taken_E and halt_E pulsed in 3rd cycle -> ignored; stall 6 cycles; state RUN afterward, halted=0.
REQ-036 halt_E pulse in RUN -> halted=1, stall=1, flush_DE=1 held for 20+ cycles; rst_l=0 one cycle -> halted=0, stall_cycles=0, flush=1 during reset.
REQ-037 STALL_CNT_W=4, ext_hold=1 for 20 cycles -> stall_cycles reaches 15 and holds at 15.
REQ-038 rst_l=0 during MULTI (mc_cycles=6, 2nd stall cycle) -> next cycle RUN, stall=0 with all inputs 0.
